// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack: program counter with a hardware return-address stack.
//
// Each enabled cycle the 3-bit opcode from the control unit chooses the next
// program counter: hold, increment, relative add/subtract, absolute jump,
// call (push pc+1 and jump) or return (pop).
//
// Illegal opcodes, a call on a full stack and a return on an empty stack are
// all errors. On any error pc and sp hold, and a sticky err flag is set. That
// flag stays set until clr_err is seen on an enabled cycle. If an error and
// clr_err arrive in the same cycle, the set takes priority.
//
// Parameters:
//   WIDTH     - pc / offset width in bits (>= 4)
//   DEPTH     - number of return-stack entries (power of two, >= 2)
//   RESET_VEC - pc value loaded by reset
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   en          in   cycle enable; 0 holds pc, sp, stack and err
//   op          in   operation select (see op_e)
//   offset      in   relative offset or absolute target
//   clr_err     in   synchronous clear of err (only when en=1)
//   pc          out  current program counter (registered)
//   sp          out  number of valid stack entries, 0..DEPTH
//   stack_full  out  sp == DEPTH
//   stack_empty out  sp == 0
//   err         out  sticky error flag
// -----------------------------------------------------------------------------
module pc_stack #(
    parameter int                 WIDTH     = 16,
    parameter int                 DEPTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       err
);

    localparam int AW  = $clog2(DEPTH);   // stack index width
    localparam int SPW = AW + 1;          // sp must also represent DEPTH

    localparam logic [SPW-1:0]   SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0]   SP_ONE  = SPW'(1);
    localparam logic [AW-1:0]    IDX_ONE = AW'(1);
    localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_JMP  = 3'b100,
        OP_CALL = 3'b101,
        OP_RET  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [SPW-1:0]   sp_q,  sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    // ------------------------------------------------------------------
    // Derived values
    // ------------------------------------------------------------------
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] pc_inc;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    op_e              op_dec;

    assign full   = (sp_q == SP_FULL);
    assign empty  = (sp_q == '0);
    assign pc_inc = pc_q + PC_ONE;        // wraps modulo 2^WIDTH

    // The write slot is sp and the top-of-stack slot is sp-1. Only the low
    // AW bits are used. When the stack is full, wr_idx aliases slot 0, which
    // is harmless because a push on a full stack is blocked. When the stack
    // is empty, rd_idx wraps, which is harmless because a pop on an empty
    // stack is blocked.
    assign wr_idx = sp_q[AW-1:0];
    assign rd_idx = sp_q[AW-1:0] - IDX_ONE;

    assign op_dec = op_e'(op);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        stack_d = stack_q;

        if (en) begin
            // Clear first, so that any error raised below overrides it.
            if (clr_err) begin
                err_d = 1'b0;
            end

            unique case (op_dec)
                OP_HOLD: ;
                OP_INC:  pc_d = pc_inc;
                OP_ADD:  pc_d = pc_q + offset;
                OP_SUB:  pc_d = pc_q - offset;
                OP_JMP:  pc_d = offset;
                OP_CALL: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[wr_idx] = pc_inc;
                        sp_d            = sp_q + SP_ONE;
                        pc_d            = offset;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d = sp_q - SP_ONE;
                        pc_d = stack_q[rd_idx];
                    end
                end
                OP_ILL:  err_d = 1'b1;
                default: err_d = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack contents are not reset. After reset sp=0, so no stale entry can
    // be read before it has been rewritten by a push.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc          = pc_q;
    assign sp          = sp_q;
    assign err         = err_q;
    assign stack_full  = full;
    assign stack_empty = empty;

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack: self-checking bench for pc_stack (WIDTH=16, DEPTH=8,
// RESET_VEC=16'h0100).
//
// The bench has three parts:
//   - A table of directed vectors.
//   - A full/overflow/underflow sequence, checked against a small
//     return-address list kept by the bench.
//   - An asynchronous mid-cycle reset case.
//
// Timing: inputs are driven on the falling edge and outputs are sampled on
// the following falling edge, after the active rising edge has passed.
// -----------------------------------------------------------------------------
module tb_pc_stack;

    localparam int               WIDTH     = 16;
    localparam int               DEPTH     = 8;
    localparam logic [WIDTH-1:0] RESET_VEC = 16'h0100;
    localparam int               SPW       = $clog2(DEPTH) + 1;
    localparam int               EW        = WIDTH + SPW + 3;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    // ---------------- DUT ----------------
    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] offset;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic [SPW-1:0]   sp;
    logic             stack_full;
    logic             stack_empty;
    logic             err;

    pc_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VEC (RESET_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .op          (op),
        .offset      (offset),
        .clr_err     (clr_err),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vector record ----------------
    typedef struct {
        logic             en;
        logic [2:0]       op;
        logic [WIDTH-1:0] offset;
        logic             clr;
        logic [WIDTH-1:0] exp_pc;
        logic [SPW-1:0]   exp_sp;
        logic             exp_err;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            checks;
    int            errors;

    function automatic logic [EW-1:0] pack_exp(input logic [WIDTH-1:0] p,
                                               input logic [SPW-1:0]   s,
                                               input logic             e);
        logic f;
        logic m;
        f = (s == SPW'(DEPTH));
        m = (s == '0);
        return {p, s, e, f, m};
    endfunction

    task automatic check(input string name);
        logic [EW-1:0] exp_v;
        logic [EW-1:0] got_v;
        got_v  = {pc, sp, err, stack_full, stack_empty};
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL %s: got pc=%h sp=%0d err=%b full=%b empty=%b, expected pc=%h sp=%0d err=%b full=%b empty=%b",
                         name, pc, sp, err, stack_full, stack_empty,
                         exp_v[EW-1 -: WIDTH], exp_v[SPW+2:3], exp_v[2],
                         exp_v[1], exp_v[0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge. It drives one cycle of inputs, lets one
    // rising edge pass, and then checks the outputs on the next falling edge.
    task automatic drive(input vec_t v, input string name);
        en      = v.en;
        op      = v.op;
        offset  = v.offset;
        clr_err = v.clr;
        exp_q.push_back(pack_exp(v.exp_pc, v.exp_sp, v.exp_err));
        @(posedge clk);
        @(negedge clk);
        check(name);
    endtask

    function automatic vec_t mk(input logic en_i, input logic [2:0] op_i,
                                input logic [WIDTH-1:0] off_i, input logic clr_i,
                                input logic [WIDTH-1:0] p, input logic [SPW-1:0] s,
                                input logic e);
        vec_t v;
        v.en = en_i; v.op = op_i; v.offset = off_i; v.clr = clr_i;
        v.exp_pc = p; v.exp_sp = s; v.exp_err = e;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] ret_model[$];
    logic [WIDTH-1:0] cur_pc;
    logic [WIDTH-1:0] tgt;
    vec_t             v;

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        en      = 1'b0;
        op      = OP_HOLD;
        offset  = '0;
        clr_err = 1'b0;

        // Directed table.
        vecs.push_back(mk(1, OP_INC,  16'h0000, 0, 16'h0101, 0, 0));
        vecs.push_back(mk(1, OP_INC,  16'h0000, 0, 16'h0102, 0, 0));
        vecs.push_back(mk(1, OP_INC,  16'h0000, 0, 16'h0103, 0, 0));
        vecs.push_back(mk(1, OP_ADD,  16'h0010, 0, 16'h0113, 0, 0));
        vecs.push_back(mk(1, OP_SUB,  16'h0200, 0, 16'hFF13, 0, 0));  // borrow wraps
        vecs.push_back(mk(1, OP_JMP,  16'hFFFF, 0, 16'hFFFF, 0, 0));
        vecs.push_back(mk(1, OP_INC,  16'h0000, 0, 16'h0000, 0, 0));  // INC wraps
        vecs.push_back(mk(1, OP_JMP,  16'h0040, 0, 16'h0040, 0, 0));
        vecs.push_back(mk(1, OP_CALL, 16'h1000, 0, 16'h1000, 1, 0));
        vecs.push_back(mk(1, OP_CALL, 16'h2000, 0, 16'h2000, 2, 0));
        vecs.push_back(mk(1, OP_RET,  16'h0000, 0, 16'h1001, 1, 0));
        vecs.push_back(mk(1, OP_RET,  16'h0000, 0, 16'h0041, 0, 0));
        vecs.push_back(mk(1, OP_RET,  16'h0000, 0, 16'h0041, 0, 1));  // underflow
        vecs.push_back(mk(1, OP_HOLD, 16'h0000, 1, 16'h0041, 0, 0));  // clear
        vecs.push_back(mk(1, OP_ILL,  16'h1234, 0, 16'h0041, 0, 1));  // illegal op
        for (int i = 0; i < 5; i++)                                    // en=0 holds everything
            vecs.push_back(mk(0, OP_INC, 16'h0000, 1, 16'h0041, 0, 1));
        vecs.push_back(mk(1, OP_ILL,  16'h0000, 1, 16'h0041, 0, 1));  // set beats clear
        vecs.push_back(mk(1, OP_HOLD, 16'h0000, 1, 16'h0041, 0, 0));
        vecs.push_back(mk(1, OP_JMP,  16'hFFFF, 0, 16'hFFFF, 0, 0));
        vecs.push_back(mk(1, OP_CALL, 16'h0500, 0, 16'h0500, 1, 0));  // pushes 0x0000
        vecs.push_back(mk(1, OP_RET,  16'h0000, 0, 16'h0000, 0, 0));  // wrapped return
        vecs.push_back(mk(1, OP_CALL, 16'h0700, 0, 16'h0700, 1, 0));  // CALL then RET, no bubble
        vecs.push_back(mk(1, OP_RET,  16'h0000, 0, 16'h0001, 0, 0));
        vecs.push_back(mk(1, OP_SUB,  16'h0001, 0, 16'h0000, 0, 0));

        // Reset state.
        repeat (2) @(negedge clk);
        exp_q.push_back(pack_exp(RESET_VEC, 0, 0));
        check("reset_state");
        reset = 1'b1;

        foreach (vecs[i]) drive(vecs[i], $sformatf("vec%0d", i));

        // Fill the stack completely, then overflow it.
        cur_pc = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            tgt = 16'h1000 + 16'(i * 16);
            ret_model.push_back(cur_pc + 16'h0001);
            cur_pc = tgt;
            drive(mk(1, OP_CALL, tgt, 0, cur_pc, SPW'(i + 1), 0), $sformatf("fill%0d", i));
        end
        drive(mk(1, OP_CALL, 16'h3000, 0, cur_pc, SPW'(DEPTH), 1), "overflow_call");

        // Unwind the stack completely, then underflow it.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cur_pc = ret_model.pop_back();
            drive(mk(1, OP_RET, 16'h0000, 0, cur_pc, SPW'(i), 1), $sformatf("unwind%0d", i));
        end
        drive(mk(1, OP_RET, 16'h0000, 0, cur_pc, 0, 1), "underflow_ret");
        drive(mk(1, OP_HOLD, 16'h0000, 1, cur_pc, 0, 0), "clr_pulse");

        // Asynchronous reset in the middle of a cycle, with the stack
        // partly filled and err set.
        drive(mk(1, OP_CALL, 16'h4000, 0, 16'h4000, 1, 0), "pre_rst_call0");
        drive(mk(1, OP_CALL, 16'h4100, 0, 16'h4100, 2, 0), "pre_rst_call1");
        drive(mk(1, OP_CALL, 16'h4200, 0, 16'h4200, 3, 0), "pre_rst_call2");
        drive(mk(1, OP_ILL,  16'h0000, 0, 16'h4200, 3, 1), "pre_rst_ill");
        en = 1'b1;
        op = OP_INC;
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(pack_exp(RESET_VEC, 0, 0));
        check("async_reset");
        @(negedge clk);
        exp_q.push_back(pack_exp(RESET_VEC, 0, 0));
        check("reset_held");
        reset = 1'b1;
        drive(mk(1, OP_RET, 16'h0000, 0, RESET_VEC, 0, 1), "ret_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised successor to the 16-bit program counter. Adds configurable width, a reset vector, and an absolute jump.
- Adds a hardware return-address stack for call/return, with a sticky error flag.
- Sits in the fetch path: drives the instruction address each cycle from a 3-bit opcode supplied by the control unit.

Parameters:
- WIDTH, 16, PC and offset width in bits (≥4).
- DEPTH, 8, return-stack entries (power of 2, ≥2).
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  cycle enable; 0 = hold all state.
- op  in  3  operation select (encoding below).
- offset  in  WIDTH  relative offset or absolute target.
- clr_err  in  1  synchronous clear of err.
- pc  out  WIDTH  current program counter (registered).
- sp  out  log2(DEPTH)+1  number of valid stack entries.
- stack_full  out  1  sp == DEPTH (combinational from sp).
- stack_empty  out  1  sp == 0 (combinational from sp).
- err  out  1  sticky: illegal op, push on full, or pop on empty.

Behaviour:
- Reset (reset=0, async): pc=RESET_VEC, sp=0, err=0. Stack contents are don't-care. All outputs are valid during reset.
- All updates occur on the rising clk edge when en=1. With en=0, pc, sp, stack and err hold; clr_err is also ignored.
- Opcodes (all arithmetic is modulo 2^WIDTH; carry/borrow is discarded, no flag):
  - 000 HOLD: no change.
  - 001 INC: pc ← pc+1.
  - 010 ADD: pc ← pc+offset.
  - 011 SUB: pc ← pc−offset.
  - 100 JMP: pc ← offset.
  - 101 CALL: stack[sp] ← pc+1, sp ← sp+1, pc ← offset.
  - 110 RET: sp ← sp−1, pc ← stack[sp−1].
  - 111 illegal: pc/sp hold, err ← 1.
- CALL with stack_full: no push, pc holds, err ← 1.
- RET with stack_empty: pc/sp hold, err ← 1.
- Latency: new pc is visible the cycle after the op edge. A CALL immediately followed by a RET returns to the call address + 1. Back-to-back CALL/RET need no bubbles.
- pc=2^WIDTH−1 with INC wraps to 0. A pushed return address of pc+1 wraps the same way.
- err:
  - Set by any error condition above.
  - Cleared when clr_err=1 and en=1.
  - If an error and clr_err occur in the same cycle, set wins (err=1).
- Stack is LIFO in a register array indexed by sp, with no read-during-write hazard: CALL and RET never occur in the same cycle.
- Reset asserted mid-operation aborts the op. pc=RESET_VEC immediately (async); no partial push survives since sp=0.
- op is don't-care while reset=0.

Test Plan:
- Reset with RESET_VEC=16'h0100, then INC ×3 → pc=0x0103, sp=0, err=0.
- pc=0x0103: ADD offset=0x0010 → 0x0113; SUB offset=0x0200 → 0xFF13 (wrap); JMP 0xFFFF then INC → 0x0000.
- From pc=0x0040: CALL 0x1000, CALL 0x2000, RET, RET → pc sequence 0x1000, 0x2000, 0x1001, 0x0041. sp goes 1, 2, 1, 0; stack_empty=1 at the end.
- DEPTH=8: 8 CALLs → stack_full=1, sp=8. A 9th CALL 0x3000 leaves pc unchanged and sets err=1. 8 RETs unwind correctly; a further RET holds pc and keeps err=1. A clr_err pulse → err=0.
- op=111 → err=1, pc holds. With en=0 and op=INC for 5 cycles, pc is unchanged. Error and clr_err in the same cycle leaves err=1.
- After 3 CALLs (sp=3), assert reset asynchronously mid-cycle → pc=RESET_VEC before the next edge, sp=0, err=0. A RET after release sets err=1.
